// File: rtl/cancela_controller_n.sv
// cancela_controller_n
//
// Controller for N_GATES vehicle barriers that share a single passage lane.
// A round-robin arbiter lets at most one barrier open at a time. Each open
// barrier times its crossing against MIN_CYCLES/MAX_CYCLES. A sticky alarm
// latches on forced entry into a closed barrier or on an abnormal crossing.
//
// Parameters:
//   N_GATES     number of barriers (>= 2)
//   MIN_CYCLES  minimum cycles `entrando` must stay high for a valid crossing
//   MAX_CYCLES  maximum cycles `entrando` may stay high before the alarm fires
//   WAIT_CYCLES cycles an open barrier waits for `entrando` before closing
//   CNT_W       per-gate counter width, holds max(MAX_CYCLES+1, WAIT_CYCLES)
//
// Ports:
//   clk_2      clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   chega      vehicle waiting at barrier i
//   entrando   crossing sensor of barrier i active
//   alarm_clr  clears alarme and alarm_src
//   aberta     barrier i open (one-hot or zero), registered
//   alarme     latched alarm, registered
//   alarm_src  sticky per-barrier alarm cause, registered
//   passagens  count of valid crossings, wraps 255 -> 0, registered
module cancela_controller_n #(
  parameter int N_GATES     = 2,
  parameter int MIN_CYCLES  = 1,
  parameter int MAX_CYCLES  = 3,
  parameter int WAIT_CYCLES = 8,
  parameter int CNT_W       = 4
) (
  input  logic               clk_2,
  input  logic               reset,
  input  logic [N_GATES-1:0] chega,
  input  logic [N_GATES-1:0] entrando,
  input  logic               alarm_clr,
  output logic [N_GATES-1:0] aberta,
  output logic               alarme,
  output logic [N_GATES-1:0] alarm_src,
  output logic [7:0]         passagens
);

  localparam int RR_W = (N_GATES > 1) ? $clog2(N_GATES) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_CYCLES);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] SAT_C     = CNT_W'(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    FECHADA  = 2'd0,
    ABERTA   = 2'd1,
    PASSANDO = 2'd2
  } gate_state_t;

  gate_state_t      state_q [N_GATES];
  gate_state_t      state_d [N_GATES];
  logic [CNT_W-1:0] cnt_q   [N_GATES];
  logic [CNT_W-1:0] cnt_d   [N_GATES];

  logic [RR_W-1:0]    rr_q;
  logic [RR_W-1:0]    rr_d;
  logic               all_closed;
  logic               grant_valid;
  logic [RR_W-1:0]    grant_idx;
  logic [N_GATES-1:0] set_evt;
  logic               pass_evt;

  // Position `off` steps after `base` in the circular gate order.
  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= N_GATES) s = s - N_GATES;
    return s;
  endfunction

  // The lane is free only when no barrier is open or being crossed.
  always_comb begin
    all_closed = 1'b1;
    for (int i = 0; i < N_GATES; i++) begin
      if (state_q[i] != FECHADA) all_closed = 1'b0;
    end
  end

  // Round-robin arbiter: scan from rr and grant the first requester whose
  // crossing sensor is quiet. A gate with entrando high is being forced, so
  // it must not be opened in the same cycle.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_GATES; k++) begin
      if (!grant_valid && all_closed &&
          chega[wrap_idx(int'(rr_q), k)] && !entrando[wrap_idx(int'(rr_q), k)]) begin
        grant_valid = 1'b1;
        grant_idx   = RR_W'(wrap_idx(int'(rr_q), k));
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_valid) begin
      if (int'(grant_idx) == N_GATES - 1) rr_d = '0;
      else                                rr_d = grant_idx + RR_W'(1);
    end
  end

  // Per-gate next-state logic. set_evt collects every alarm cause raised
  // this cycle; pass_evt flags a crossing that ended inside the valid window.
  always_comb begin
    set_evt  = '0;
    pass_evt = 1'b0;
    for (int i = 0; i < N_GATES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        FECHADA: begin
          if (entrando[i]) begin
            set_evt[i] = 1'b1;
          end else if (grant_valid && int'(grant_idx) == i) begin
            state_d[i] = ABERTA;
            cnt_d[i]   = '0;
          end
        end
        ABERTA: begin
          if (entrando[i]) begin
            state_d[i] = PASSANDO;
            cnt_d[i]   = CNT_ONE;
          end else if (cnt_q[i] == WAIT_LAST) begin
            state_d[i] = FECHADA;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        PASSANDO: begin
          if (entrando[i]) begin
            // The alarm fires only on the step into saturation, so it is
            // raised once per overlong crossing.
            if (cnt_q[i] == MAX_C) set_evt[i] = 1'b1;
            if (cnt_q[i] != SAT_C) cnt_d[i] = cnt_q[i] + CNT_ONE;
          end else begin
            state_d[i] = FECHADA;
            cnt_d[i]   = '0;
            if (cnt_q[i] >= MIN_C && cnt_q[i] <= MAX_C) pass_evt   = 1'b1;
            if (cnt_q[i] <  MIN_C)                      set_evt[i] = 1'b1;
          end
        end
        default: begin
          state_d[i] = FECHADA;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // State register. aberta is decoded from the next state so the output
  // itself comes straight from a flop.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      for (int i = 0; i < N_GATES; i++) begin
        state_q[i] <= FECHADA;
        cnt_q[i]   <= '0;
        aberta[i]  <= 1'b0;
      end
      rr_q <= '0;
    end else begin
      for (int i = 0; i < N_GATES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        aberta[i]  <= (state_d[i] != FECHADA);
      end
      rr_q <= rr_d;
    end
  end

  // Alarm latch and crossing counter. A set event in the same cycle as
  // alarm_clr wins, so a still-active cause is never lost.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      alarme    <= 1'b0;
      alarm_src <= '0;
      passagens <= '0;
    end else begin
      if (alarm_clr) begin
        alarme    <= |set_evt;
        alarm_src <= set_evt;
      end else begin
        alarme    <= alarme | (|set_evt);
        alarm_src <= alarm_src | set_evt;
      end
      if (pass_evt) passagens <= passagens + 8'd1;
    end
  end

endmodule

// File: tb/tb_cancela_controller_n.sv
// tb_cancela_controller_n
//
// Self-checking bench for cancela_controller_n with default parameters.
// A lane-level reference model tracks which single gate (if any) holds the
// lane, how long it has been open or crossed, and the alarm/counter outputs.
// Directed scenarios are followed by randomized traffic and a wrap run.
module tb_cancela_controller_n;

  localparam int N     = 2;
  localparam int MINC  = 1;
  localparam int MAXC  = 3;
  localparam int WAITC = 8;

  logic         clk_2 = 1'b0;
  logic         reset;
  logic [N-1:0] chega;
  logic [N-1:0] entrando;
  logic         alarm_clr;
  logic [N-1:0] aberta;
  logic         alarme;
  logic [N-1:0] alarm_src;
  logic [7:0]   passagens;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: index of the gate holding the lane (-1 = none),
  // whether its vehicle is crossing, and cycles spent in the current phase.
  int           m_open;
  bit           m_crossing;
  int           m_time;
  int           m_rr;
  logic [7:0]   m_pass;
  logic         m_alarm;
  logic [N-1:0] m_src;

  cancela_controller_n #(
    .N_GATES    (N),
    .MIN_CYCLES (MINC),
    .MAX_CYCLES (MAXC),
    .WAIT_CYCLES(WAITC),
    .CNT_W      (4)
  ) dut (
    .clk_2    (clk_2),
    .reset    (reset),
    .chega    (chega),
    .entrando (entrando),
    .alarm_clr(alarm_clr),
    .aberta   (aberta),
    .alarme   (alarme),
    .alarm_src(alarm_src),
    .passagens(passagens)
  );

  always #5 clk_2 = ~clk_2;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    m_open     = -1;
    m_crossing = 1'b0;
    m_time     = 0;
    m_rr       = 0;
    m_pass     = '0;
    m_alarm    = 1'b0;
    m_src      = '0;
  endtask

  task automatic modelStep(input logic [N-1:0] ch, input logic [N-1:0] en,
                           input logic clr);
    logic [N-1:0] ev;
    ev = '0;
    for (int i = 0; i < N; i++) begin
      if (i != m_open && en[i]) ev[i] = 1'b1;
    end
    if (m_open < 0) begin
      for (int k = 0; k < N; k++) begin
        int g;
        g = (m_rr + k) % N;
        if (ch[g] && !en[g]) begin
          m_open     = g;
          m_crossing = 1'b0;
          m_time     = 0;
          m_rr       = (g + 1) % N;
          break;
        end
      end
    end else if (!m_crossing) begin
      if (en[m_open]) begin
        m_crossing = 1'b1;
        m_time     = 1;
      end else if (m_time == WAITC - 1) begin
        m_open = -1;
      end else begin
        m_time++;
      end
    end else begin
      if (en[m_open]) begin
        if (m_time == MAXC) ev[m_open] = 1'b1;
        if (m_time < MAXC + 1) m_time++;
      end else begin
        if (m_time >= MINC && m_time <= MAXC) m_pass = m_pass + 8'd1;
        if (m_time < MINC) ev[m_open] = 1'b1;
        m_open = -1;
      end
    end
    if (clr) begin
      m_alarm = |ev;
      m_src   = ev;
    end else begin
      m_alarm = m_alarm | (|ev);
      m_src   = m_src | ev;
    end
  endtask

  function automatic logic [N-1:0] expAberta();
    logic [N-1:0] e;
    e = '0;
    if (m_open >= 0) e[m_open] = 1'b1;
    return e;
  endfunction

  // Drive one cycle of inputs, clock it, advance the model, sample at +1.
  task automatic applyStimulus(input logic [N-1:0] ch, input logic [N-1:0] en,
                               input logic clr, input logic rst);
    chega     = ch;
    entrando  = en;
    alarm_clr = clr;
    reset     = rst;
    @(posedge clk_2);
    if (rst) modelReset();
    else     modelStep(ch, en, clr);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    n_checks++;
    assert (aberta === expAberta()) else begin
      n_errors++;
      $error("[TB] FAIL %s.aberta observed=%b expected=%b", tag, aberta, expAberta());
    end
    n_checks++;
    assert (alarme === m_alarm) else begin
      n_errors++;
      $error("[TB] FAIL %s.alarme observed=%b expected=%b", tag, alarme, m_alarm);
    end
    n_checks++;
    assert (alarm_src === m_src) else begin
      n_errors++;
      $error("[TB] FAIL %s.alarm_src observed=%b expected=%b", tag, alarm_src, m_src);
    end
    n_checks++;
    assert (passagens === m_pass) else begin
      n_errors++;
      $error("[TB] FAIL %s.passagens observed=%0d expected=%0d", tag, passagens, m_pass);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [N-1:0] gb;
    logic [N-1:0] rnd_en;
    int           waited;

    reset     = 1'b1;
    chega     = '0;
    entrando  = '0;
    alarm_clr = 1'b0;
    modelReset();

    // Reset state
    applyStimulus('0, '0, 1'b0, 1'b1);
    applyStimulus('0, '0, 1'b0, 1'b1);
    checkOutput("reset");
    checkValue("reset_aberta", 32'(aberta), 32'd0);

    // Basic pass: one-cycle request, two-cycle crossing
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
    checkOutput("basic_grant");
    checkValue("basic_open0", 32'(aberta), 32'd1);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(2'b00, 2'b01, 1'b0, 1'b0);
      checkOutput("basic_cross");
      checkValue("basic_open_cross", 32'(aberta), 32'd1);
    end
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    checkOutput("basic_close");
    checkValue("basic_closed", 32'(aberta), 32'd0);
    checkValue("basic_passagens", 32'(passagens), 32'd1);
    checkValue("basic_alarme", 32'(alarme), 32'd0);

    // Arbitration: both request continuously, grants alternate 0,1,0
    applyStimulus('0, '0, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      waited = 0;
      while (aberta == '0 && waited < 4) begin
        applyStimulus(2'b11, 2'b00, 1'b0, 1'b0);
        checkOutput("arb_wait");
        waited++;
      end
      gb = '0;
      gb[r % 2] = 1'b1;
      checkValue("arb_order", 32'(aberta), 32'(gb));
      for (int c = 0; c < 2; c++) begin
        applyStimulus(2'b11, gb, 1'b0, 1'b0);
        checkOutput("arb_cross");
        checkValue("arb_not_both", 32'(aberta != 2'b11), 32'd1);
      end
      applyStimulus(2'b11, 2'b00, 1'b0, 1'b0);
      checkOutput("arb_close");
      checkValue("arb_closed", 32'(aberta), 32'd0);
    end
    checkValue("arb_passagens", 32'(passagens), 32'd3);

    // Overlong crossing: entrando high five cycles
    applyStimulus('0, '0, 1'b0, 1'b1);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
    for (int h = 1; h <= 5; h++) begin
      applyStimulus(2'b00, 2'b01, 1'b0, 1'b0);
      checkOutput("long_cross");
      if (h == 3) checkValue("long_no_alarm_yet", 32'(alarme), 32'd0);
      if (h == 4) begin
        checkValue("long_alarme", 32'(alarme), 32'd1);
        checkValue("long_src", 32'(alarm_src), 32'd1);
      end
    end
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    checkOutput("long_close");
    checkValue("long_closed", 32'(aberta), 32'd0);
    checkValue("long_passagens", 32'(passagens), 32'd0);

    // Forced entry on closed gate 1, then clear with and without cause
    applyStimulus('0, '0, 1'b0, 1'b1);
    applyStimulus(2'b00, 2'b10, 1'b0, 1'b0);
    checkOutput("forced_set");
    checkValue("forced_src", 32'(alarm_src), 32'd2);
    applyStimulus(2'b00, 2'b10, 1'b1, 1'b0);
    checkOutput("forced_clr_blocked");
    checkValue("forced_alarme_held", 32'(alarme), 32'd1);
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0);
    checkOutput("forced_clr");
    checkValue("forced_alarme_clr", 32'(alarme), 32'd0);
    checkValue("forced_src_clr", 32'(alarm_src), 32'd0);

    // Forced entry on gate 1 while gate 0 is open
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b10, 1'b0, 1'b0);
    checkOutput("forced_other_open");
    checkValue("forced_other_aberta", 32'(aberta), 32'd1);
    checkValue("forced_other_src", 32'(alarm_src), 32'd2);

    // Timeout: open with no crossing, closes after WAITC cycles
    applyStimulus('0, '0, 1'b0, 1'b1);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
    checkOutput("timeout_grant");
    for (int c = 0; c < WAITC - 1; c++) begin
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
      checkOutput("timeout_wait");
      checkValue("timeout_still_open", 32'(aberta), 32'd1);
    end
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    checkOutput("timeout_close");
    checkValue("timeout_closed", 32'(aberta), 32'd0);
    checkValue("timeout_alarme", 32'(alarme), 32'd0);

    // Reset during a crossing
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b01, 1'b0, 1'b0);
    checkOutput("midreset_crossing");
    applyStimulus(2'b00, 2'b01, 1'b0, 1'b1);
    checkOutput("midreset");
    checkValue("midreset_all_zero",
               32'({aberta, alarme, alarm_src, passagens}), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      rnd_en = '0;
      for (int i = 0; i < N; i++) begin
        if (i == m_open) rnd_en[i] = ($urandom_range(0, 3) != 0);
        else             rnd_en[i] = ($urandom_range(0, 15) == 0);
      end
      applyStimulus(N'($urandom), rnd_en, ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 99) == 0));
      checkOutput("random");
    end

    // Wrap: 256 valid crossings bring passagens back to 0
    applyStimulus('0, '0, 1'b0, 1'b1);
    for (int c = 0; c < 256; c++) begin
      applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
      applyStimulus(2'b00, 2'b01, 1'b0, 1'b0);
      applyStimulus(2'b00, 2'b01, 1'b0, 1'b0);
      applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
      checkOutput("wrap_step");
      if (c == 254) checkValue("wrap_255", 32'(passagens), 32'd255);
    end
    checkValue("wrap_zero", 32'(passagens), 32'd0);
    checkValue("wrap_no_alarm", 32'(alarme), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
